io_stream_buffer: RTL and testbench

// - Word/byte bridge between the pipeline core's I/O port and a byte-wide UART pair.
// - Buffers 32-bit out words from the core, serialises them LSB-byte-first to UART TX.
// - Packs incoming UART RX bytes into 32-bit words for the core's in_data.
// - Generates the core's out_stall/in_stall so a blocked I/O instruction holds the pipeline.

---
 rtl/io_stream_buffer.sv | 164 ++++++++++++++++
 tb/tb_io_stream_buffer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_stream_buffer.sv
// rtl/io_stream_buffer.sv - word/byte bridge between core I/O port and a byte-wide UART pair
//
// Purpose:
//   Out words from the core are queued in a TX word FIFO and serialised
//   LSB byte first to the UART transmitter. Bytes from the UART receiver are
//   packed LSB first into 32-bit words and queued in an RX word FIFO for the
//   core. Stall outputs hold a blocked I/O instruction in the pipeline.
//
// Ports:
//   clk, rst              system clock; asynchronous active-high reset
//   out_issued, out_data  core out-word request and its data
//   out_stall             core must hold its out instruction
//   in_issued             core in-word request
//   in_data, in_stall     RX FIFO head word (0 when empty); core must hold its in
//   tx_data, tx_valid     byte stream to UART TX
//   tx_ready              UART TX accepts a byte
//   rx_data, rx_valid     byte strobe from UART RX
//   rx_overflow           sticky: a completed RX word was dropped on a full FIFO
module io_stream_buffer #(
   parameter int TX_DEPTH_LOG2 = 4,
   parameter int RX_DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        out_issued,
   input  logic [31:0] out_data,
   output logic        out_stall,
   input  logic        in_issued,
   output logic [31:0] in_data,
   output logic        in_stall,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_overflow
);

   localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
   localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
   localparam logic [TX_DEPTH_LOG2:0] TX_ONE = 1;

   // ---------------- TX word FIFO ----------------
   logic [31:0]              tx_mem [TX_DEPTH];
   logic [TX_DEPTH_LOG2:0]   tx_wptr, tx_rptr, tx_count;
   logic                     tx_full, tx_empty, tx_push, tx_pop;
   logic [31:0]              tx_head;

   assign tx_count = tx_wptr - tx_rptr;
   assign tx_empty = (tx_wptr == tx_rptr);
   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign tx_full  = (tx_wptr[TX_DEPTH_LOG2] != tx_rptr[TX_DEPTH_LOG2]) &&
                     (tx_wptr[TX_DEPTH_LOG2-1:0] == tx_rptr[TX_DEPTH_LOG2-1:0]);
   assign tx_push  = out_issued & ~tx_full;
   assign out_stall = out_issued & tx_full;
   assign tx_head  = tx_mem[tx_rptr[TX_DEPTH_LOG2-1:0]];

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wptr[TX_DEPTH_LOG2-1:0]] <= out_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wptr <= '0;
         tx_rptr <= '0;
      end else begin
         if (tx_push) tx_wptr <= tx_wptr + TX_ONE;
         if (tx_pop)  tx_rptr <= tx_rptr + TX_ONE;
      end
   end

   // ---------------- Serializer FSM ----------------
   typedef enum logic {S_IDLE, S_SEND} ser_state_t;
   ser_state_t state, state_next;
   logic [1:0] byte_idx, byte_idx_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         byte_idx <= 2'd0;
      end else begin
         state    <= state_next;
         byte_idx <= byte_idx_next;
      end
   end

   always_comb begin
      state_next    = state;
      byte_idx_next = byte_idx;
      tx_valid      = 1'b0;
      tx_pop        = 1'b0;
      case (state)
         S_IDLE: begin
            if (!tx_empty) state_next = S_SEND;
         end
         S_SEND: begin
            tx_valid = 1'b1;
            if (tx_ready) begin
               if (byte_idx == 2'd3) begin
                  tx_pop        = 1'b1;
                  byte_idx_next = 2'd0;
                  // A word pushed this same cycle is not counted here; it
                  // is picked up from IDLE one cycle later.
                  if (tx_count <= TX_ONE) state_next = S_IDLE;
               end else begin
                  byte_idx_next = byte_idx + 2'd1;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Head word and byte index are frozen while a byte waits for tx_ready,
   // so tx_data stays stable without a separate output register.
   assign tx_data = tx_valid ? tx_head[{byte_idx, 3'b000} +: 8] : 8'h00;

   // ---------------- RX assembler + word FIFO ----------------
   localparam logic [RX_DEPTH_LOG2:0] RX_ONE = 1;
   logic [31:0]              rx_mem [RX_DEPTH];
   logic [RX_DEPTH_LOG2:0]   rx_wptr, rx_rptr;
   logic                     rx_full, rx_empty, rx_push, rx_pop, rx_complete;
   logic [1:0]               rx_slot;
   logic [23:0]              rx_partial;
   logic [31:0]              rx_word;

   assign rx_empty    = (rx_wptr == rx_rptr);
   assign rx_full     = (rx_wptr[RX_DEPTH_LOG2] != rx_rptr[RX_DEPTH_LOG2]) &&
                        (rx_wptr[RX_DEPTH_LOG2-1:0] == rx_rptr[RX_DEPTH_LOG2-1:0]);
   assign rx_complete = rx_valid & (rx_slot == 2'd3);
   assign rx_push     = rx_complete & ~rx_full;
   assign rx_pop      = in_issued & ~rx_empty;
   assign in_stall    = in_issued & rx_empty;
   assign rx_word     = {rx_data, rx_partial};
   assign in_data     = rx_empty ? 32'h0 : rx_mem[rx_rptr[RX_DEPTH_LOG2-1:0]];

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wptr[RX_DEPTH_LOG2-1:0]] <= rx_word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_wptr     <= '0;
         rx_rptr     <= '0;
         rx_slot     <= 2'd0;
         rx_partial  <= 24'h0;
         rx_overflow <= 1'b0;
      end else begin
         if (rx_push) rx_wptr <= rx_wptr + RX_ONE;
         if (rx_pop)  rx_rptr <= rx_rptr + RX_ONE;
         if (rx_valid) begin
            rx_slot <= rx_slot + 2'd1;
            case (rx_slot)
               2'd0:    rx_partial[7:0]   <= rx_data;
               2'd1:    rx_partial[15:8]  <= rx_data;
               2'd2:    rx_partial[23:16] <= rx_data;
               default: ;
            endcase
         end
         if (rx_complete & rx_full) rx_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_io_stream_buffer.sv
// tb/tb_io_stream_buffer.sv - randomized self-checking bench for io_stream_buffer
module tb_io_stream_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        out_issued;
   logic [31:0] out_data;
   logic        out_stall;
   logic        in_issued;
   logic [31:0] in_data;
   logic        in_stall;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_overflow;

   always #5 clk = ~clk;

   io_stream_buffer #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
      .clk(clk), .rst(rst),
      .out_issued(out_issued), .out_data(out_data), .out_stall(out_stall),
      .in_issued(in_issued), .in_data(in_data), .in_stall(in_stall),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_overflow(rx_overflow)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: word queues plus byte progress counters.
   logic [31:0] m_txq[$];
   int          m_tx_byte;
   logic [31:0] m_rxq[$];
   logic [31:0] m_rx_part;
   int          m_rx_k;
   logic        m_ovf;
   logic        prev_hold;
   logic [7:0]  prev_data;
   int          idle_cnt;

   logic        o_tx_valid, o_out_stall, o_in_stall;
   logic [7:0]  o_tx_data;
   logic [31:0] o_in_data;

   task automatic model_clear();
      m_txq.delete();
      m_rxq.delete();
      m_tx_byte = 0;
      m_rx_part = 32'h0;
      m_rx_k    = 0;
      m_ovf     = 1'b0;
      prev_hold = 1'b0;
      idle_cnt  = 0;
   endtask

   task automatic set_idle_inputs();
      out_issued = 1'b0;
      out_data   = 32'h0;
      in_issued  = 1'b0;
      tx_ready   = 1'b0;
      rx_data    = 8'h00;
      rx_valid   = 1'b0;
   endtask

   // One clock cycle: check outputs mid-cycle, advance the model, then move
   // to just after the next rising edge.
   task automatic step();
      logic [31:0] w;
      bit tx_full_now, rx_empty_now, rx_full_now;
      @(negedge clk);
      o_tx_valid  = tx_valid;
      o_tx_data   = tx_data;
      o_out_stall = out_stall;
      o_in_stall  = in_stall;
      o_in_data   = in_data;
      tx_full_now  = (m_txq.size() == 16);
      rx_empty_now = (m_rxq.size() == 0);
      rx_full_now  = (m_rxq.size() == 16);

      check("out_stall", o_out_stall, out_issued && tx_full_now);
      check("in_stall", o_in_stall, in_issued && rx_empty_now);
      check("in_data", o_in_data, rx_empty_now ? 32'h0 : m_rxq[0]);
      check("rx_overflow", rx_overflow, m_ovf);
      if (m_txq.size() == 0) check("tx_valid_empty", o_tx_valid, 0);
      if (o_tx_valid && m_txq.size() > 0) begin
         w = m_txq[0];
         check("tx_data", o_tx_data, w[8*m_tx_byte +: 8]);
      end
      if (prev_hold) begin
         check("tx_hold_valid", o_tx_valid, 1);
         check("tx_hold_data", o_tx_data, prev_data);
      end
      if (m_txq.size() > 0 && !o_tx_valid) idle_cnt++;
      else idle_cnt = 0;
      if (m_txq.size() > 0) check("tx_live", idle_cnt > 1, 0);
      prev_hold = o_tx_valid && !tx_ready;
      prev_data = o_tx_data;

      if (o_tx_valid && tx_ready && m_txq.size() > 0) begin
         if (m_tx_byte == 3) begin
            void'(m_txq.pop_front());
            m_tx_byte = 0;
         end else begin
            m_tx_byte++;
         end
      end
      if (out_issued && !tx_full_now) m_txq.push_back(out_data);
      if (in_issued && !rx_empty_now) void'(m_rxq.pop_front());
      if (rx_valid) begin
         m_rx_part[8*m_rx_k +: 8] = rx_data;
         if (m_rx_k == 3) begin
            if (rx_full_now) m_ovf = 1'b1;
            else m_rxq.push_back(m_rx_part);
            m_rx_k = 0;
         end else begin
            m_rx_k++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Reset lands mid-cycle to exercise the asynchronous path.
   task automatic do_reset();
      #3;
      set_idle_inputs();
      rst = 1'b1;
      #1;
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_in_data", in_data, 0);
      check("rst_out_stall", out_stall, 0);
      check("rst_in_stall", in_stall, 0);
      check("rst_rx_overflow", rx_overflow, 0);
      model_clear();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      step();
      rx_valid = 1'b0;
   endtask

   initial begin
      bit released;
      int guard;
      rst = 1'b1;
      set_idle_inputs();
      model_clear();
      @(posedge clk);
      #1;
      do_reset();

      // Single word serialisation with minimum latency.
      tx_ready = 1'b1;
      out_issued = 1'b1;
      out_data = 32'h11223344;
      step();
      check("lat_n", o_tx_valid, 0);
      out_issued = 1'b0;
      step();
      check("lat_n1", o_tx_valid, 0);
      step(); check("byte0", {o_tx_valid, o_tx_data}, 9'h144);
      step(); check("byte1", {o_tx_valid, o_tx_data}, 9'h133);
      step(); check("byte2", {o_tx_valid, o_tx_data}, 9'h122);
      step(); check("byte3", {o_tx_valid, o_tx_data}, 9'h111);
      step(); check("after_word", o_tx_valid, 0);

      // Fill TX FIFO with tx_ready low; 17th word stalls until one drains.
      tx_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         out_issued = 1'b1;
         out_data = $urandom;
         step();
         check("fill_no_stall", o_out_stall, 0);
      end
      out_data = $urandom;
      for (int i = 0; i < 3; i++) begin
         step();
         check("full_stall", o_out_stall, 1);
      end
      tx_ready = 1'b1;
      released = 1'b0;
      for (int i = 0; i < 10 && !released; i++) begin
         step();
         released = !o_out_stall;
      end
      check("stall_release", released, 1);
      out_issued = 1'b0;
      guard = 0;
      while (m_txq.size() > 0 && guard < 300) begin
         tx_ready = ($urandom_range(0, 3) != 0);
         step();
         guard++;
      end
      check("tx_drain", m_txq.size(), 0);
      tx_ready = 1'b0;
      step();

      // RX packing with gaps.
      send_rx(8'hEF); step();
      send_rx(8'hBE); step(); step();
      send_rx(8'hAD);
      send_rx(8'hDE);
      in_issued = 1'b1;
      step();
      check("rx_word", o_in_data, 32'hDEADBEEF);
      check("rx_word_stall", o_in_stall, 0);
      in_issued = 1'b0;

      // in_issued on empty FIFO stalls until the word completes.
      in_issued = 1'b1;
      step(); check("empty_stall0", o_in_stall, 1);
      step(); check("empty_stall1", o_in_stall, 1);
      send_rx(8'h10);
      send_rx(8'h20);
      send_rx(8'h30);
      send_rx(8'h40);
      check("complete_cycle_stall", o_in_stall, 1);
      step();
      check("stall_drop", o_in_stall, 0);
      check("stall_drop_data", o_in_data, 32'h40302010);
      in_issued = 1'b0;
      step();

      // Overflow: 16 words fill RX, 17th is dropped; contents unchanged.
      for (int i = 0; i < 68; i++) send_rx(8'($urandom));
      step();
      check("overflow_set", rx_overflow, 1);
      check("overflow_depth", m_rxq.size(), 16);
      in_issued = 1'b1;
      for (int i = 0; i < 16; i++) step();
      step();
      check("drained_stall", o_in_stall, 1);
      in_issued = 1'b0;

      // Randomised traffic.
      for (int i = 0; i < 800; i++) begin
         if (!(out_issued && o_out_stall)) out_data = $urandom;
         out_issued = ($urandom_range(0, 2) == 0);
         tx_ready   = ($urandom_range(0, 9) < 7);
         rx_valid   = ($urandom_range(0, 9) < 4);
         rx_data    = 8'($urandom);
         in_issued  = ($urandom_range(0, 9) < 3);
         step();
      end
      set_idle_inputs();
      step();

      // Reset while mid-SEND and with a partial RX word.
      do_reset();
      tx_ready = 1'b1;
      out_issued = 1'b1;
      out_data = 32'hA1B2C3D4;
      send_rx(8'h55);
      out_issued = 1'b0;
      send_rx(8'h66);
      step();
      check("pre_rst_byte0", {o_tx_valid, o_tx_data}, 9'h1D4);
      tx_ready = 1'b0;
      step();
      check("pre_rst_byte1", {o_tx_valid, o_tx_data}, 9'h1C3);
      do_reset();
      send_rx(8'h01);
      send_rx(8'h02);
      send_rx(8'h03);
      send_rx(8'h04);
      in_issued = 1'b1;
      step();
      check("post_rst_rx", o_in_data, 32'h04030201);
      check("post_rst_tx", o_tx_valid, 0);
      in_issued = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
